psum_deskew_acc: RTL and testbench
==================================

PSUM_DESKEW_ACC -- requirements
Module: psum_deskew_acc

Interface
REQ-001 SHALL have parameter ROWS, default 8, number of systolic-array rows (partial-sum lanes).
REQ-002 SHALL have parameter PARTIAL_SUM_BW, default 19, width of each incoming partial sum.
REQ-003 SHALL have parameter ACC_BW, default 32, width of each accumulator lane.
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port rstn  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port in_valid  input  1  qualifies lane 0 of psum_in in the current cycle.
REQ-007 SHALL have port psum_in  input  ROWS*PARTIAL_SUM_BW  signed right-edge partial sums; lane r at bits [r*PARTIAL_SUM_BW +: PARTIAL_SUM_BW].
REQ-008 SHALL have port num_pass  input  4  passes to accumulate per result; sampled with in_valid on the first pass of a group.
REQ-009 SHALL have port flush  input  1  synchronous clear of deskew pipeline, pass counter and accumulators.
REQ-010 SHALL have port out_valid  output  1  result vector available.
REQ-011 SHALL have port out_ready  input  1  consumer accepts the result.
REQ-012 SHALL have port out_data  output  ROWS*ACC_BW  signed accumulated results, lane r at bits [r*ACC_BW +: ACC_BW].
REQ-013 SHALL have port ovf_err  output  1  sticky: a completed result was dropped.
REQ-014 SHALL have port clr_err  input  1  synchronous clear of ovf_err.

Function
REQ-015 SHALL delay lane r by ROWS-1-r register stages (lane ROWS-1 zero stages), so lane r sampled r cycles after lane 0 aligns with it.
REQ-016 SHALL delay in_valid and num_pass by ROWS-1 stages to form aligned_valid/aligned_np, matching the aligned vector.
REQ-017 SHALL sign-extend each aligned lane from PARTIAL_SUM_BW to ACC_BW before accumulation.
REQ-018 SHALL keep a pass counter pc (0..15); on aligned_valid with pc==0, acc[r] <= sext(lane r) and group length N <= aligned_np, with N=0 treated as 1.
REQ-019 SHALL, on aligned_valid with pc>0, set acc[r] <= acc[r] + sext(lane r), wrapping two's complement modulo 2^ACC_BW (no saturation).
REQ-020 SHALL, on the aligned_valid completing pass N, load out_data with the final sums (including that pass), set out_valid, and return pc to 0; otherwise pc increments.
REQ-021 SHALL make latency, single pass: in_valid at cycle 0, lane ROWS-1 at cycle ROWS-1, out_valid high in cycle ROWS.
REQ-022 SHALL hold out_valid and out_data stable until a cycle with out_valid && out_ready; out_valid then clears unless a new result completes that cycle.
REQ-023 SHALL, on completion with out_valid=1 and out_ready=1 in the same cycle, load the new result and keep out_valid=1.
REQ-024 SHALL, on completion with out_valid=1 and out_ready=0, drop the new result, keep out_data unchanged, set ovf_err, and still return pc to 0.
REQ-025 SHALL give clr_err priority under a simultaneous set: ovf_err ends the cycle at 0.
REQ-026 SHALL, on flush, zero deskew stages, valid pipeline, pc and accumulators next edge; out_valid/out_data/ovf_err unaffected; in-flight inputs discarded.
REQ-027 SHALL ignore psum_in lanes while their aligned valid bit is 0 (no accumulator change).

Reset
REQ-028 SHALL, while rstn=0, asynchronously force out_valid=0, out_data=0, ovf_err=0, pc=0, accumulators=0 and all pipeline stages (data and valid) to 0.
REQ-029 SHALL, on reset mid-group, discard partial accumulation; first aligned_valid after release starts a new group.

Verification
REQ-030 Single pass: ROWS=8, num_pass=1, in_valid cycle 0, lane r = r+1 presented at cycle r -> out_valid cycle 8, lane r of out_data = r+1.
REQ-031 Multi-pass signed: num_pass=3, every lane -5, +262143, -262144 on three valid passes -> one out_valid, each lane = -6 sign-extended to 32 bits.
REQ-032 Backpressure: out_ready=0, two single-pass results complete -> first held, ovf_err=1; clr_err one cycle -> ovf_err=0, first result still held.
REQ-033 Simultaneous accept/complete: out_ready=1 on the cycle a new result completes -> new data loaded, out_valid stays 1, ovf_err=0.
REQ-034 Flush mid-group: num_pass=4, flush after 2 passes, then single pass value 7 with num_pass=1 -> out_data lanes = 7.
REQ-035 Async reset: rstn low between clock edges mid-group with out_valid=1 -> out_valid, out_data, ovf_err 0 immediately; next group unaffected by old sums.

Source files
------------

// File: rtl/psum_deskew_acc.sv
// psum_deskew_acc
// Collects the staggered partial sums from the right edge of a systolic array,
// realigns them into one vector, and accumulates that vector over a programmable
// number of passes. Completed results go out through a valid/ready register slice.
//
// Ports
//   clk        single clock, all state on the rising edge
//   rstn       asynchronous active-low reset
//   in_valid   qualifies lane 0 of psum_in this cycle (lane r follows r cycles later)
//   psum_in    ROWS signed partial sums, lane r at [r*PARTIAL_SUM_BW +: PARTIAL_SUM_BW]
//   num_pass   passes per result, sampled with in_valid on a group's first pass (0 => 1)
//   flush      synchronous clear of the deskew pipeline, pass counter and accumulators
//   out_valid  result vector available
//   out_ready  consumer accepts the result
//   out_data   ROWS signed accumulated results, lane r at [r*ACC_BW +: ACC_BW]
//   ovf_err    sticky: a completed result was dropped while the output was full
//   clr_err    synchronous clear of ovf_err (wins over a simultaneous set)
module psum_deskew_acc #(
  parameter int unsigned ROWS           = 8,
  parameter int unsigned PARTIAL_SUM_BW = 19,
  parameter int unsigned ACC_BW         = 32
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         in_valid,
  input  logic [ROWS*PARTIAL_SUM_BW-1:0] psum_in,
  input  logic [3:0]                   num_pass,
  input  logic                         flush,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [ROWS*ACC_BW-1:0]       out_data,
  output logic                         ovf_err,
  input  logic                         clr_err
);

  // ---------------------------------------------------------------------------
  // Deskew: lane r is delayed ROWS-1-r stages so every lane of a pass lines up
  // with lane ROWS-1, which arrives last and passes straight through.
  // ---------------------------------------------------------------------------
  logic [PARTIAL_SUM_BW-1:0] aligned [ROWS];

  for (genvar r = 0; r < ROWS; r++) begin : g_lane
    localparam int unsigned Depth = ROWS - 1 - r;
    if (Depth == 0) begin : g_thru
      assign aligned[r] = psum_in[r*PARTIAL_SUM_BW +: PARTIAL_SUM_BW];
    end else begin : g_dly
      logic [PARTIAL_SUM_BW-1:0] stage_q [Depth];
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          for (int i = 0; i < Depth; i++) stage_q[i] <= '0;
        end else if (flush) begin
          for (int i = 0; i < Depth; i++) stage_q[i] <= '0;
        end else begin
          stage_q[0] <= psum_in[r*PARTIAL_SUM_BW +: PARTIAL_SUM_BW];
          for (int i = 1; i < Depth; i++) stage_q[i] <= stage_q[i-1];
        end
      end
      assign aligned[r] = stage_q[Depth-1];
    end
  end

  // ---------------------------------------------------------------------------
  // Valid / num_pass travel with lane 0, so they see ROWS-1 stages as well.
  // ---------------------------------------------------------------------------
  logic       aligned_valid;
  logic [3:0] aligned_np;

  if (ROWS == 1) begin : g_vthru
    assign aligned_valid = in_valid;
    assign aligned_np    = num_pass;
  end else begin : g_vdly
    localparam int unsigned VDepth = ROWS - 1;
    logic       vld_q [VDepth];
    logic [3:0] np_q  [VDepth];
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        for (int i = 0; i < VDepth; i++) begin
          vld_q[i] <= 1'b0;
          np_q[i]  <= '0;
        end
      end else if (flush) begin
        for (int i = 0; i < VDepth; i++) begin
          vld_q[i] <= 1'b0;
          np_q[i]  <= '0;
        end
      end else begin
        vld_q[0] <= in_valid;
        np_q[0]  <= num_pass;
        for (int i = 1; i < VDepth; i++) begin
          vld_q[i] <= vld_q[i-1];
          np_q[i]  <= np_q[i-1];
        end
      end
    end
    assign aligned_valid = vld_q[VDepth-1];
    assign aligned_np    = np_q[VDepth-1];
  end

  // ---------------------------------------------------------------------------
  // Accumulation over a group of passes
  // ---------------------------------------------------------------------------
  logic [ACC_BW-1:0] ext    [ROWS];
  logic [ACC_BW-1:0] acc_q  [ROWS];
  logic [ACC_BW-1:0] acc_d  [ROWS];
  logic [3:0]        pc_q, pc_d;
  logic [3:0]        n_q, n_d;
  logic [3:0]        n_eff;
  logic              done;

  always_comb begin
    for (int r = 0; r < ROWS; r++) ext[r] = ACC_BW'($signed(aligned[r]));
  end

  always_comb begin
    pc_d  = pc_q;
    n_d   = n_q;
    n_eff = n_q;
    done  = 1'b0;
    for (int r = 0; r < ROWS; r++) acc_d[r] = acc_q[r];

    if (flush) begin
      // An aligned pass in the flush cycle is in flight and is discarded too.
      pc_d = '0;
      n_d  = '0;
      for (int r = 0; r < ROWS; r++) acc_d[r] = '0;
    end else if (aligned_valid) begin
      if (pc_q == 4'd0) begin
        n_eff = (aligned_np == 4'd0) ? 4'd1 : aligned_np;
        for (int r = 0; r < ROWS; r++) acc_d[r] = ext[r];
      end else begin
        for (int r = 0; r < ROWS; r++) acc_d[r] = acc_q[r] + ext[r];
      end
      n_d = n_eff;
      if (({1'b0, pc_q} + 5'd1) == {1'b0, n_eff}) begin
        done = 1'b1;
        pc_d = '0;
      end else begin
        pc_d = pc_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pc_q <= '0;
      n_q  <= '0;
      for (int r = 0; r < ROWS; r++) acc_q[r] <= '0;
    end else begin
      pc_q <= pc_d;
      n_q  <= n_d;
      for (int r = 0; r < ROWS; r++) acc_q[r] <= acc_d[r];
    end
  end

  // ---------------------------------------------------------------------------
  // Output slice: a result arriving while the slot is full and not being drained
  // is dropped and flagged.
  // ---------------------------------------------------------------------------
  logic                   out_valid_q, out_valid_d;
  logic [ROWS*ACC_BW-1:0] out_data_q, out_data_d;
  logic                   ovf_q, ovf_d;
  logic                   drop;

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    drop        = 1'b0;
    if (done) begin
      if (!out_valid_q || out_ready) begin
        out_valid_d = 1'b1;
        for (int r = 0; r < ROWS; r++) out_data_d[r*ACC_BW +: ACC_BW] = acc_d[r];
      end else begin
        drop = 1'b1;
      end
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
    ovf_d = clr_err ? 1'b0 : (ovf_q | drop);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      ovf_q       <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      ovf_q       <= ovf_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign ovf_err   = ovf_q;

endmodule

// File: tb/tb_psum_deskew_acc.sv
// Bench for psum_deskew_acc: a pass-level model (queue of issued passes, group
// sums, output slot) checked against the DUT every cycle, plus literal checks.
module tb_psum_deskew_acc;

  localparam int R  = 8;
  localparam int PW = 19;
  localparam int AW = 32;
  localparam int VW = R * PW;
  localparam int OW = R * AW;

  logic          clk;
  logic          rstn;
  logic          in_valid;
  logic [VW-1:0] psum_in;
  logic [3:0]    num_pass;
  logic          flush;
  logic          out_valid;
  logic          out_ready;
  logic [OW-1:0] out_data;
  logic          ovf_err;
  logic          clr_err;

  psum_deskew_acc #(
    .ROWS          (R),
    .PARTIAL_SUM_BW(PW),
    .ACC_BW        (AW)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .in_valid (in_valid),
    .psum_in  (psum_in),
    .num_pass (num_pass),
    .flush    (flush),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .ovf_err  (ovf_err),
    .clr_err  (clr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  task automatic chk(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h, want %h", name, cyc, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Model: a pass is a vector whose lane r is presented at cycle start+r; it is
  // counted toward its group at cycle start+R-1 and the result is visible next.
  // ---------------------------------------------------------------------------
  typedef struct {
    int            start;
    int            np;
    logic [VW-1:0] vec;
  } pass_t;

  pass_t         q[$];
  logic [AW-1:0] gs [R];
  int            g_pc = 0;
  int            g_n  = 1;
  logic          m_valid = 1'b0;
  logic [OW-1:0] m_data  = '0;
  logic          m_ovf   = 1'b0;

  function automatic logic [AW-1:0] sx(input logic [PW-1:0] v);
    return {{(AW-PW){v[PW-1]}}, v};
  endfunction

  function automatic logic [VW-1:0] splat(input int v);
    logic [VW-1:0] t;
    for (int r = 0; r < R; r++) t[r*PW +: PW] = PW'(v);
    return t;
  endfunction

  function automatic logic [OW-1:0] exp_all(input int v);
    logic [OW-1:0] t;
    for (int r = 0; r < R; r++) t[r*AW +: AW] = AW'(v);
    return t;
  endfunction

  task automatic model_reset();
    q.delete();
    g_pc    = 0;
    m_valid = 1'b0;
    m_data  = '0;
    m_ovf   = 1'b0;
  endtask

  task automatic model_step(input int c);
    pass_t keep[$];
    bit    done = 1'b0;
    bit    drop = 1'b0;
    int    idx  = -1;
    if (flush) begin
      foreach (q[i]) if (q[i].start > c) keep.push_back(q[i]);
      q    = keep;
      g_pc = 0;
    end else begin
      foreach (q[i]) if (q[i].start + R - 1 == c) idx = i;
      if (idx >= 0) begin
        if (g_pc == 0) begin
          g_n = (q[idx].np == 0) ? 1 : q[idx].np;
          for (int r = 0; r < R; r++) gs[r] = sx(q[idx].vec[r*PW +: PW]);
        end else begin
          for (int r = 0; r < R; r++) gs[r] = gs[r] + sx(q[idx].vec[r*PW +: PW]);
        end
        g_pc++;
        if (g_pc == g_n) begin
          done = 1'b1;
          g_pc = 0;
        end
        q.delete(idx);
      end
    end
    if (done) begin
      if (!m_valid || out_ready) begin
        m_valid = 1'b1;
        for (int r = 0; r < R; r++) m_data[r*AW +: AW] = gs[r];
      end else begin
        drop = 1'b1;
      end
    end else if (m_valid && out_ready) begin
      m_valid = 1'b0;
    end
    if (clr_err) m_ovf = 1'b0;
    else if (drop) m_ovf = 1'b1;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      if (rstn) model_step(cyc);
      cyc++;
    end
  end

  // Compare, then drive this cycle's inputs; lanes with no pass carry junk.
  initial begin
    forever begin
      @(negedge clk);
      chk("out_valid", OW'(out_valid), OW'(m_valid));
      chk("out_data", out_data, m_data);
      chk("ovf_err", OW'(ovf_err), OW'(m_ovf));
      in_valid = 1'b0;
      num_pass = 4'($urandom);
      for (int r = 0; r < R; r++) psum_in[r*PW +: PW] = PW'($urandom);
      foreach (q[i]) begin
        if (q[i].start == cyc) begin
          in_valid = 1'b1;
          num_pass = 4'(q[i].np);
        end
        for (int r = 0; r < R; r++)
          if (q[i].start + r == cyc) psum_in[r*PW +: PW] = q[i].vec[r*PW +: PW];
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Directed stimulus
  // ---------------------------------------------------------------------------
  task automatic nxt();
    @(negedge clk);
    #2;
  endtask

  task automatic issue(input int off, input int np, input logic [VW-1:0] vec);
    pass_t p;
    p.start = cyc + off;
    p.np    = np;
    p.vec   = vec;
    q.push_back(p);
  endtask

  task automatic wait_valid(output int seen);
    seen = -1;
    for (int i = 0; i < 40; i++) begin
      nxt();
      if (out_valid) begin
        seen = cyc;
        break;
      end
    end
    chk("wait_out_valid", OW'(out_valid), OW'(1));
  endtask

  task automatic run_to(input int target);
    while (cyc < target) nxt();
  endtask

  task automatic accept();
    out_ready = 1'b1;
    nxt();
    out_ready = 1'b0;
  endtask

  int            s;
  int            seen;
  logic [VW-1:0] ramp;
  logic [OW-1:0] ramp_exp;

  initial begin
    rstn      = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
    clr_err   = 1'b0;
    for (int r = 0; r < R; r++) begin
      ramp[r*PW +: PW]     = PW'(r + 1);
      ramp_exp[r*AW +: AW] = AW'(r + 1);
    end
    repeat (3) @(negedge clk);
    #1;
    chk("reset_valid", OW'(out_valid), OW'(0));
    chk("reset_data", out_data, '0);
    chk("reset_ovf", OW'(ovf_err), OW'(0));
    rstn = 1'b1;
    nxt();

    // Single pass, lane r = r+1: visible R cycles after in_valid
    issue(1, 1, ramp);
    s = cyc + 1;
    wait_valid(seen);
    chk("single_latency", OW'(seen), OW'(s + R));
    chk("single_data", out_data, ramp_exp);
    accept();
    chk("single_drained", OW'(out_valid), OW'(0));

    // Three signed passes: -5 + 262143 - 262144 = -6
    issue(1, 3, splat(-5));
    issue(2, 3, splat(262143));
    issue(3, 3, splat(-262144));
    wait_valid(seen);
    chk("multi_data", out_data, exp_all(-6));
    chk("multi_lane0", OW'(out_data[AW-1:0]), OW'(32'hFFFF_FFFA));
    accept();

    // Backpressure: second result dropped, first held
    issue(1, 1, splat(10));
    issue(3, 1, splat(20));
    wait_valid(seen);
    repeat (4) nxt();
    chk("bp_ovf_set", OW'(ovf_err), OW'(1));
    chk("bp_held", out_data, exp_all(10));
    clr_err = 1'b1;
    nxt();
    clr_err = 1'b0;
    chk("bp_ovf_clr", OW'(ovf_err), OW'(0));
    chk("bp_still_valid", OW'(out_valid), OW'(1));
    chk("bp_still_data", out_data, exp_all(10));

    // Drop and clr_err in the same cycle: clear wins
    issue(1, 1, splat(40));
    s = cyc + 1;
    run_to(s + R - 1);
    clr_err = 1'b1;
    nxt();
    clr_err = 1'b0;
    chk("clr_priority", OW'(ovf_err), OW'(0));
    chk("clr_held", out_data, exp_all(10));

    // Accept and complete together: new data, valid stays high
    issue(1, 1, splat(30));
    s = cyc + 1;
    run_to(s + R - 1);
    out_ready = 1'b1;
    nxt();
    out_ready = 1'b0;
    chk("sim_valid", OW'(out_valid), OW'(1));
    chk("sim_data", out_data, exp_all(30));
    chk("sim_ovf", OW'(ovf_err), OW'(0));
    accept();

    // Flush mid-group (2 of 4 passes counted, a third in flight)
    s = cyc + 1;
    issue(1, 4, splat(100));
    issue(2, 4, splat(100));
    issue(6, 4, splat(55));
    run_to(s + R + 1);
    flush = 1'b1;
    nxt();
    flush = 1'b0;
    issue(1, 1, splat(7));
    wait_valid(seen);
    chk("flush_data", out_data, exp_all(7));
    accept();

    // Async reset mid-group with a held result and a pending error
    issue(1, 1, splat(9));
    wait_valid(seen);
    issue(1, 1, splat(11));
    issue(2, 2, splat(1000));
    s = cyc + 2;
    run_to(s + R);
    chk("pre_reset_ovf", OW'(ovf_err), OW'(1));
    @(posedge clk);
    #2;
    rstn = 1'b0;
    model_reset();
    #1;
    chk("areset_valid", OW'(out_valid), OW'(0));
    chk("areset_data", out_data, '0);
    chk("areset_ovf", OW'(ovf_err), OW'(0));
    @(negedge clk);
    #1;
    rstn = 1'b1;
    nxt();
    issue(1, 2, splat(3));
    issue(2, 2, splat(4));
    wait_valid(seen);
    chk("post_reset_data", out_data, exp_all(7));
    accept();
    repeat (3) nxt();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
